addsub_cla_iter: RTL and testbench
==================================

Name: addsub_cla_iter

Overview:
- Parametrised, multi-cycle adder/subtractor for the ALU datapath; successor to the fixed 4-bit carry-lookahead adder.
- Processes a WIDTH-bit operand pair one SLICE-bit carry-lookahead slice per clock, least-significant slice first, with the carry registered between slices.
- Adds subtract mode, signed-overflow and zero flags, and valid/ready handshakes on input and output so it can sit between pipeline stages of the 8-bit ALU and wider variants.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a positive multiple of SLICE.
- SLICE, 4, bits resolved per cycle by one carry-lookahead slice; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B+cin; 1 = A-B-cin (cin acts as borrow-in).
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Reset:
  - Synchronous, active-high: on a rising edge with rst=1, state <= IDLE.
  - s, cout, ovf, zero and out_valid <= 0; slice counter <= 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
  - rst dominates every other event, including mid-RUN and DONE; an in-flight operation is discarded with no out_valid pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1, out_valid=0. An accept (in_valid & in_ready at an edge) captures a, b_eff, carry0 and sub, clears s, sets the counter to 0 and enters RUN.
  - b_eff = sub ? ~b : b; carry0 = sub ? ~cin : cin.
  - RUN: in_ready=0. Each cycle, slice k computes bits [k*SLICE +: SLICE] from a and b_eff with the registered carry, using generate/propagate lookahead (Gi=ai&bi, Pi=ai^bi, ci+1 = Gi | Pi&ci, flattened per slice).
  - At the end of each RUN cycle, the slice sum is written into s, the slice carry-out is registered and the counter increments.
  - After slice NSLICE-1: cout <= its carry-out; ovf <= (a[MSB]==b_eff[MSB]) & (s[MSB]!=a[MSB]); zero <= (final s==0); state -> DONE.
  - DONE: out_valid=1, in_ready=0. s and all flags hold stable until out_ready=1 at an edge, then state -> IDLE; in_ready is 1 in the following cycle.
  - No same-cycle accept while in DONE (no bypass).
- Latency: out_valid rises NSLICE cycles after the accepting edge (WIDTH=8: 2 cycles). Throughput is one operation per NSLICE+2 cycles with out_ready held high.
- Operand capture: a, b, sub and cin are sampled only at the accepting edge; changes afterwards have no effect.
- Partial results: s holds partial results during RUN; consumers use it only while out_valid=1.
- in_valid while busy is ignored (in_ready=0); the upstream holds its data.
- Wrap-around: the result is modulo 2^WIDTH; cout carries the extra bit.
- Flag semantics for sub: cout=1 means A >= B+borrow (unsigned).

Test Plan:
- WIDTH=8, add: a=0x7F, b=0x01, cin=0 -> after 2 cycles, s=0x80, cout=0, ovf=1, zero=0, out_valid=1.
- Add wrap: a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, ovf=0, zero=1. Separately, a=0x0F, b=0x01 -> s=0x10, verifying the inter-slice carry.
- Sub: a=0x05, b=0x05, cin=0 -> s=0x00, cout=1, zero=1. Then a=0x00, b=0x01, cin=0 -> s=0xFF, cout=0, ovf=0. Then a=0x80, b=0x01 -> s=0x7F, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> s and flags stable, in_ready=0, a second in_valid is not accepted. Release -> in_ready=1 one cycle later, and the next operand set completes normally.
- Reset mid-RUN: assert rst for 1 cycle after acceptance -> no out_valid, outputs=0, in_ready=1 the cycle after rst drops. Reset while in DONE -> out_valid drops at that edge.
- WIDTH=16, SLICE=4: a=0x00FF, b=0x0001, cin=1 -> s=0x0101 after exactly 4 cycles. Also a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, zero=1.

Source files
------------

// File: rtl/addsub_cla_iter.sv
// addsub_cla_iter: multi-cycle add/sub, one SLICE-bit lookahead slice per clock; ports: in_valid/in_ready/a/b/sub/cin in, out_valid/out_ready/s/cout/ovf/zero out
module addsub_cla_iter #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, s_n;
  logic [SLICE-1:0] sa, sb, g, p, sum;
  logic [SLICE:0] c;
  logic [CW-1:0] cnt;
  logic carry, pp, last, accept;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign last = int'(cnt) == NSLICE - 1;
  always_comb begin
    sa = a_r[int'(cnt)*SLICE +: SLICE];
    sb = b_r[int'(cnt)*SLICE +: SLICE];
    g = sa & sb;
    p = sa ^ sb;
    c = '0;
    c[0] = carry;
    pp = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & carry);
    end
    sum = p ^ c[SLICE-1:0];
    s_n = s;
    s_n[int'(cnt)*SLICE +: SLICE] = sum;
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
      cnt <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      s <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      s <= s_n;
      carry <= c[SLICE];
      cnt <= cnt + 1'b1;
      if (last) begin
        cout <= c[SLICE];
        ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_n[WIDTH-1] != a_r[WIDTH-1]);
        zero <= s_n == '0;
      end
    end
  end
endmodule

// File: tb/tb_addsub_cla_iter.sv
// tb_addsub_cla_iter: directed table-driven checks of the iterative adder/subtractor at 8 and 16 bits
module tb_addsub_cla_iter;
  logic clk = 0, rst = 1, sub = 0, cin = 0, out_ready = 1;
  logic iv8 = 0, iv16 = 0;
  logic [15:0] a = 0, b = 0;
  logic ir8, ov8, co8, of8, z8, ir16, ov16, co16, of16, z16;
  logic [7:0] s8;
  logic [15:0] s16;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  addsub_cla_iter #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .sub(sub), .cin(cin), .out_valid(ov8), .out_ready(out_ready), .s(s8),
    .cout(co8), .ovf(of8), .zero(z8));

  addsub_cla_iter #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(ov16), .out_ready(out_ready), .s(s16),
    .cout(co16), .ovf(of16), .zero(z16));

  typedef struct {
    logic w;
    logic [15:0] a, b;
    logic sub, cin;
    logic [15:0] s;
    logic cout, ovf, zero;
    int lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic w, input logic [15:0] va, vb, input logic vs, vc);
    @(negedge clk);
    a = va; b = vb; sub = vs; cin = vc;
    chk("in_ready_idle", w ? ir16 : ir8, 1);
    if (w) iv16 = 1; else iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0; iv16 = 0;
  endtask

  task automatic wait_done(input logic w, output int lat);
    lat = 0;
    while (!(w ? ov16 : ov8) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input vec_t v);
    int lat;
    out_ready = 1;
    start(v.w, v.a, v.b, v.sub, v.cin);
    wait_done(v.w, lat);
    chk("latency", lat, v.lat);
    chk("s", v.w ? s16 : {8'h0, s8}, v.s);
    chk("cout", v.w ? co16 : co8, v.cout);
    chk("ovf", v.w ? of16 : of8, v.ovf);
    chk("zero", v.w ? z16 : z8, v.zero);
    @(posedge clk); #1;
    chk("back_to_idle", v.w ? ir16 : ir8, 1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{0, 16'h7F, 16'h01, 0, 0, 16'h80, 0, 1, 0, 2};
    vecs[1]  = '{0, 16'hFF, 16'h01, 0, 0, 16'h00, 1, 0, 1, 2};
    vecs[2]  = '{0, 16'h0F, 16'h01, 0, 0, 16'h10, 0, 0, 0, 2};
    vecs[3]  = '{0, 16'h05, 16'h05, 1, 0, 16'h00, 1, 0, 1, 2};
    vecs[4]  = '{0, 16'h00, 16'h01, 1, 0, 16'hFF, 0, 0, 0, 2};
    vecs[5]  = '{0, 16'h80, 16'h01, 1, 0, 16'h7F, 1, 1, 0, 2};
    vecs[6]  = '{0, 16'h12, 16'h34, 0, 1, 16'h47, 0, 0, 0, 2};
    vecs[7]  = '{0, 16'h10, 16'h05, 1, 1, 16'h0A, 1, 0, 0, 2};
    vecs[8]  = '{0, 16'h80, 16'h80, 0, 0, 16'h00, 1, 1, 1, 2};
    vecs[9]  = '{1, 16'h00FF, 16'h0001, 0, 1, 16'h0101, 0, 0, 0, 4};
    vecs[10] = '{1, 16'hFFFF, 16'h0000, 0, 1, 16'h0000, 1, 0, 1, 4};
    @(posedge clk); #1;
    chk("rst_in_ready", ir8, 0);
    chk("rst_out_valid", ov8, 0);
    chk("rst_s", s8, 0);
    chk("rst_flags", {co8, of8, z8}, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", ir8, 1);
    for (int i = 0; i < 11; i++) run(vecs[i]);
    // backpressure: hold result, ignore new operands, then release
    out_ready = 0;
    start(0, 16'h7F, 16'h01, 0, 0);
    wait_done(0, lat);
    chk("bp_latency", lat, 2);
    @(negedge clk);
    a = 16'h22; b = 16'h11; iv8 = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", ov8, 1);
      chk("bp_in_ready", ir8, 0);
      chk("bp_s", s8, 8'h80);
      chk("bp_flags", {co8, of8, z8}, 3'b010);
    end
    @(negedge clk);
    iv8 = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_ov", ov8, 0);
    chk("bp_release_ir", ir8, 1);
    run(vecs[2]);
    // reset mid-run
    start(0, 16'h7F, 16'h01, 0, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rr_out_valid", ov8, 0);
    chk("rr_s", s8, 0);
    chk("rr_flags", {co8, of8, z8}, 0);
    chk("rr_in_ready", ir8, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("rr_in_ready_after", ir8, 1);
    chk("rr_no_pulse", ov8, 0);
    // reset while holding a result
    out_ready = 0;
    start(0, 16'hFF, 16'h01, 0, 0);
    wait_done(0, lat);
    chk("rd_valid", ov8, 1);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rd_out_valid", ov8, 0);
    chk("rd_zero", z8, 0);
    @(negedge clk); rst = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("rd_in_ready", ir8, 1);
    run(vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
